// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle E-stage multiply/divide unit (restoring radix-2 divider,
// MUL_STAGES-cycle multiplier) with stall request, flush cancel and valid pulse.
module muldiv_seq #(
    parameter int MUL_STAGES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  opE,
    input  logic        signedE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        flush,
    output logic        stallE,
    output logic [31:0] hiE,
    output logic [31:0] loE,
    output logic        validE
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d, hi_q, hi_d, lo_q, lo_d;
    logic        sgn_q, sgn_d, valid_q, valid_d;
    logic        start, last;
    logic [31:0] a_mag, b_mag, rem_nx, quo_nx;
    logic [32:0] part, diff;
    logic [63:0] prod;

    assign start  = state_q == IDLE && (opE == 2'b01 || opE == 2'b10) && !flush;
    assign stallE = resetn && !flush && (start || state_q == MUL || state_q == DIV);
    assign hiE    = hi_q;
    assign loE    = lo_q;
    assign validE = valid_q && !flush;
    assign last   = state_q == MUL ? cnt_q == 6'(MUL_STAGES - 1) : cnt_q == 6'd31;
    assign a_mag  = signedE && srcaE[31] ? -srcaE : srcaE;
    assign b_mag  = sgn_q && b_q[31] ? -b_q : b_q;
    // quo_q shifts the dividend out at the top while quotient bits enter at the bottom
    assign part   = {rem_q, quo_q[31]};
    assign diff   = part - {1'b0, b_mag};
    assign rem_nx = diff[32] ? part[31:0] : diff[31:0];
    assign quo_nx = {quo_q[30:0], !diff[32]};
    assign prod   = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = opE == 2'b01 ? MUL : DIV;
                cnt_d   = '0;
                a_d     = srcaE;
                b_d     = srcbE;
                sgn_d   = signedE;
                rem_d   = '0;
                quo_d   = a_mag;
            end
            MUL: begin
                cnt_d = cnt_q + 6'd1;
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end
            end
            DIV: begin
                cnt_d = cnt_q + 6'd1;
                rem_d = rem_nx;
                quo_d = quo_nx;
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    hi_d    = b_q == '0 ? a_q : (sgn_q && a_q[31] ? -rem_nx : rem_nx);
                    lo_d    = b_q == '0 ? '1 : (sgn_q && (a_q[31] ^ b_q[31]) ? -quo_nx : quo_nx);
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors for muldiv_seq, checked every cycle against an
// occupancy/arithmetic model plus hand-computed literal results.
module tb_muldiv_seq;
    localparam int MS = 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  opE = 2'b00;
    logic        signedE = 1'b0;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        flush = 1'b0;
    logic        stallE, validE;
    logic [31:0] hiE, loE;

    int n_cmp = 0;
    int n_bad = 0;
    bit run = 0;

    // model: an op occupies E for lat+1 cycles; stall on ages 0..lat-1, valid at age lat
    bit          m_act = 0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [63:0] m_res = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_seq #(.MUL_STAGES(MS)) dut (
        .clk(clk), .resetn(resetn), .opE(opE), .signedE(signedE),
        .srcaE(srcaE), .srcbE(srcbE), .flush(flush),
        .stallE(stallE), .hiE(hiE), .loE(loE), .validE(validE)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] result(logic [1:0] op, logic s, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        ua = longint'(a);
        ub = longint'(b);
        if (op == 2'b01) return s ? 64'(sa * sb) : 64'(ua * ub);
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_act <= 0;
            m_hi  <= '0;
            m_lo  <= '0;
        end else if (flush) begin
            m_act <= 0;
        end else if (m_act) begin
            m_age <= m_age + 1;
            if (m_age + 1 == m_lat) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
            if (m_age >= m_lat) m_act <= 0;
        end else if (opE == 2'b01 || opE == 2'b10) begin
            m_act <= 1;
            m_age <= 1;
            m_lat <= opE == 2'b01 ? MS + 1 : 33;
            m_res <= result(opE, signedE, srcaE, srcbE);
        end
    end

    always @(negedge clk) begin
        logic es, ev;
        logic [31:0] eh, el;
        if (run) begin
            if (!resetn) begin
                es = 0; ev = 0; eh = '0; el = '0;
            end else begin
                ev = m_act && m_age == m_lat && !flush;
                es = !flush && (m_act ? m_age < m_lat : (opE == 2'b01 || opE == 2'b10));
                eh = m_hi;
                el = m_lo;
            end
            chk("stallE", 64'(stallE), 64'(es));
            chk("validE", 64'(validE), 64'(ev));
            chk("hiE", 64'(hiE), 64'(eh));
            chk("loE", 64'(loE), 64'(el));
        end
    end

    // entered at posedge+1 in IDLE; returns at posedge+1 of the cycle after DONE
    task automatic op_lit(input string name, input logic [1:0] op, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_stall);
        int st = 0;
        bit got = 0;
        opE = op; signedE = s; srcaE = a; srcbE = b;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (stallE) st++;
            if (validE) begin
                got = 1;
                chk({name, " result"}, {hiE, loE}, exp);
                chk({name, " stall cycles"}, 64'(st), 64'(exp_stall));
            end
            @(posedge clk); #1;
            opE = 2'b00; srcaE = $urandom; srcbE = $urandom; signedE = 1'($urandom);
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: no validE within 60 cycles, want one", name);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk); run = 1;
        step(2);
        @(negedge clk);
        chk("reset outs", {30'(0), stallE, validE, hiE}, 64'(0));
        chk("reset lo", 64'(loE), 64'(0));
        @(posedge clk); #1 resetn = 1;
        step(1);

        op_lit("udiv 100/7", 2'b10, 0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        op_lit("sdiv -7/2", 2'b10, 1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        op_lit("sdiv min/-1", 2'b10, 1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        op_lit("smul -1*2", 2'b01, 1, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        op_lit("umul ffffffff*2", 2'b01, 0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 2);
        op_lit("udiv 5/0", 2'b10, 0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 33);
        op_lit("sdiv -5/0", 2'b10, 1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 33);
        op_lit("udiv max/1", 2'b10, 0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33);
        op_lit("sdiv 7/-2", 2'b10, 1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
        op_lit("smul min*min", 2'b01, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2);
        op_lit("umul max*max", 2'b01, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2);

        opE = 2'b11; step(3);
        opE = 2'b10; flush = 1; step(1);
        opE = 2'b00; flush = 0; step(2);

        // flush on the 10th DIV cycle
        opE = 2'b10; signedE = 0; srcaE = 32'd50; srcbE = 32'd3;
        step(1); opE = 2'b00;
        step(9); flush = 1;
        #3 chk("flush stallE", 64'(stallE), 64'(0));
        step(1); flush = 0;
        step(40);
        op_lit("udiv 9/3", 2'b10, 0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // flush in DONE suppresses the valid pulse
        opE = 2'b01; signedE = 0; srcaE = 32'd3; srcbE = 32'd4;
        step(1); opE = 2'b00;
        step(1); flush = 1;
        #3 chk("flush DONE validE", 64'(validE), 64'(0));
        step(1); flush = 0;
        step(2);

        // reset on the 20th DIV cycle
        opE = 2'b10; signedE = 0; srcaE = 32'd1000; srcbE = 32'd3;
        step(1); opE = 2'b00;
        step(19);
        #2 resetn = 0;
        #1 chk("async rst stall/valid", {62'(0), stallE, validE}, 64'(0));
        chk("async rst hi/lo", {hiE, loE}, 64'(0));
        step(2); resetn = 1;
        op_lit("udiv 100/7 after rst", 2'b10, 0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
